// File: rtl/counter_pkg.sv
// Shared defaults, pin mapping constants and the counter update action type
// used by the pin_counter block.
package counter_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_DIV_W = 8;
    localparam int unsigned TC_PIN    = 7;
    localparam logic [7:0]  OEB_ALL   = 8'hFF;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_TERM
    } act_e;

endpackage

// File: rtl/pin_counter_tick_gen.sv
// Prescaler for pin_counter: emits a one-cycle tick every div+1 enabled cycles.
module tick_gen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_pre;
    logic             w_match;

    assign w_match = (r_pre == div);
    assign tick    = en && w_match;

    // A pre above a freshly lowered div keeps counting and wraps before matching.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_pre <= '0;
        end else if (en) begin
            if (w_match) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/pin_counter.sv
// Prescaled up/down counter with wrap or saturate at the limit, a terminal-count
// pulse, and an 8-bit output pin image.
module pin_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             mode_sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [7:0]       io_out,
    output logic [7:0]       io_oeb
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_tick;
    logic             w_at_term;
    logic [6:0]       w_pin_cnt;
    act_e             w_act;

    tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .div (div),
        .tick(w_tick)
    );

    assign w_at_term = up ? (r_count == '1) : (r_count == '0);

    always_comb begin
        w_act = ACT_HOLD;
        if (load) begin
            w_act = ACT_LOAD;
        end else if (w_tick) begin
            w_act = w_at_term ? ACT_TERM : ACT_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= (w_act == ACT_TERM);
            case (w_act)
                ACT_LOAD: r_count <= load_val;
                ACT_STEP: r_count <= up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
                ACT_TERM: if (!mode_sat) r_count <= up ? '0 : '1;
                default:  r_count <= r_count;
            endcase
        end
    end

    // Narrow counters sit zero-extended below the tc pin; wide ones are truncated.
    generate
        if (WIDTH >= 8) begin : g_wide
            assign w_pin_cnt = r_count[6:0];
        end else begin : g_narrow
            assign w_pin_cnt = 7'(r_count);
        end
    endgenerate

    assign count  = r_count;
    assign tc     = r_tc;
    assign io_out = {r_tc, w_pin_cnt};
    assign io_oeb = OEB_ALL;

endmodule

// File: doc/pin_counter.md
PIN_COUNTER -- requirements
Module: pin_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter DIV_W, default 8: prescaler divide-value width in bits, legal range 1..16.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: count enable; low freezes the prescaler and the counter.
REQ-006 Port up, input, 1: direction; 1 counts up, 0 counts down.
REQ-007 Port mode_sat, input, 1: 0 wraps at the limit, 1 saturates at the limit.
REQ-008 Port load, input, 1: synchronous load strobe.
REQ-009 Port load_val, input, WIDTH: value taken by count on load.
REQ-010 Port div, input, DIV_W: a count step occurs every div+1 enabled cycles.
REQ-011 Port count, output, WIDTH: current counter value, registered.
REQ-012 Port tc, output, 1: terminal-count pulse, registered.
REQ-013 Port io_out, output, 8: pin image; io_out[WIDTH-1:0] = count when WIDTH<=7, io_out[7] = tc, all other bits 0; when WIDTH>=8, io_out[6:0] = count[6:0].
REQ-014 Port io_oeb, output, 8: constant 8'hFF, all pins are outputs.

Function
REQ-015 Prescaler register pre (DIV_W bits): when en=1 and pre==div, pre<=0 and tick=1; when en=1 and pre!=div, pre<=pre+1; when en=0, pre holds.
REQ-016 With div=0, tick is asserted on every enabled cycle, so count may change on consecutive cycles.
REQ-017 Terminal value: all-ones when up=1, zero when up=0; up is sampled in the tick cycle.
REQ-018 On tick with count not at terminal: count<=count+1 when up=1, count-1 when up=0.
REQ-019 On tick with count at terminal and mode_sat=0: count wraps (max->0, 0->max), tc<=1.
REQ-020 On tick with count at terminal and mode_sat=1: count holds, tc<=1 on every such tick.
REQ-021 tc is high for exactly one cycle after each terminal tick and low otherwise; with div=0 it stays high on back-to-back terminal ticks.
REQ-022 load=1 takes priority over tick: count<=load_val, pre<=0, tc<=0; this applies regardless of en.
REQ-023 A change of div mid-count takes effect at the next comparison; if pre>div, pre increments and wraps modulo 2^DIV_W before it matches.
REQ-024 Changing up or mode_sat between ticks alters no state until the next tick.
REQ-025 Latency: count and tc update on the clock edge at the end of the tick or load cycle, never combinationally from inputs.

Reset
REQ-026 When rst=1 at a rising edge: count<=0, pre<=0, tc<=0; rst overrides load and en.
REQ-027 Reset asserted mid-prescale discards the partial prescale count; the first step after release occurs div+1 enabled cycles later.
REQ-028 io_oeb is constant and unaffected by reset; io_out follows the reset values of count and tc.

Structure
REQ-029 Package counter_pkg holds the default WIDTH (4), the default DIV_W (8), the pin-index constant TC_PIN=7, and the oeb constant 8'hFF.
REQ-030 The prescaler is a separate sub-module tick_gen (ports: clk, rst, en, clr, div, tick); clr is driven by load. pin_counter instantiates it once.
REQ-031 No latches, no gated or derived clocks, and no asynchronous logic.

Verification
REQ-032 rst=1, then en=1, up=1, div=0, mode_sat=0 for 18 cycles -> count steps 0..15,0,1; tc high only in the cycle after count goes 15->0.
REQ-033 div=3, en=1, up=1 -> count increments once every 4 cycles; en=0 for 5 cycles mid-period -> count and pre frozen, then the period resumes where it stopped.
REQ-034 mode_sat=1, up=0, load_val=2, load pulse -> count 2,1,0,0,0; tc pulses on each tick taken at 0; switching to up=1 -> count 1.
REQ-035 load=1 on the same cycle as a terminal tick with load_val=9 -> count=9, tc=0, pre=0.
REQ-036 rst asserted for 1 cycle with count=11, pre=2, div=5 -> count=0, tc=0, next step after exactly 6 enabled cycles.
REQ-037 WIDTH=8 instance -> wrap 255->0 with tc, io_out[6:0]=count[6:0], io_out[7]=tc, io_oeb=8'hFF throughout.
